// File: rtl/trace_pkg.sv
// Shared types for the write-back commit trace buffer: entry layout and limits.
package trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_entry_t;

    localparam int          TRACE_ENTRY_W = 73;
    localparam logic [15:0] DROP_CNT_MAX  = 16'hFFFF;

endpackage

// File: rtl/trace_ring_ram.sv
// Ring storage for trace entries: synchronous write, asynchronous read.
module trace_ring_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [TRACE_ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic [TRACE_ENTRY_W-1:0] rd_data
);

    logic [TRACE_ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture FIFO with commit/drop statistics.
// Define TRACE_OVERWRITE_EN to keep the newest DEPTH commits instead of the oldest.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      debug_wb_pc,
    input  logic [3:0]       debug_wb_rf_we,
    input  logic [4:0]       debug_wb_rf_wnum,
    input  logic [31:0]      debug_wb_rf_wdata,
    input  logic             clr,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [3:0]       trace_we,
    output logic [4:0]       trace_wnum,
    output logic [31:0]      trace_wdata,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [31:0]      commit_cnt,
    output logic [15:0]      drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  occ;
    logic         full;
    logic         push;
    logic         pop;
    logic         loss;
    logic         wr_adv;
    logic         rd_adv;
    logic         ram_we;
    trace_entry_t wr_entry;
    trace_entry_t rd_entry;

    // Wrap-bit pointers: the difference is the occupancy, MSB set only when full.
    assign occ  = wptr - rptr;
    assign full = occ[AW];

    assign push = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    assign pop  = trace_valid && trace_ready;
    assign loss = push && full && !pop;

`ifdef TRACE_OVERWRITE_EN
    assign wr_adv = push;
    assign rd_adv = pop || loss;
`else
    assign wr_adv = push && !loss;
    assign rd_adv = pop;
`endif

    assign ram_we = resetn && !clr && wr_adv;

    assign wr_entry = '{pc: debug_wb_pc, we: debug_wb_rf_we,
                        wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};

    trace_ring_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rptr[AW-1:0]),
        .rd_data (rd_entry)
    );

    assign trace_valid = (occ != '0);
    assign trace_pc    = rd_entry.pc;
    assign trace_we    = rd_entry.we;
    assign trace_wnum  = rd_entry.wnum;
    assign trace_wdata = rd_entry.wdata;
    assign count       = CNT_W'(occ);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            wptr       <= '0;
            rptr       <= '0;
            overflow   <= 1'b0;
            commit_cnt <= 32'd0;
            drop_cnt   <= 16'd0;
        end else begin
            if (wr_adv) wptr <= wptr + 1'b1;
            if (rd_adv) rptr <= rptr + 1'b1;
            if (push) commit_cnt <= commit_cnt + 32'd1;
            if (loss) begin
                overflow <= 1'b1;
                if (drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH = 16).
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] debug_wb_pc = '0;
    logic [3:0]  debug_wb_rf_we = '0;
    logic [4:0]  debug_wb_rf_wnum = '0;
    logic [31:0] debug_wb_rf_wdata = '0;
    logic        clr = 1'b0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [31:0] trace_pc;
    logic [3:0]  trace_we;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
    logic [4:0]  count;
    logic        overflow;
    logic [31:0] commit_cnt;
    logic [15:0] drop_cnt;

    int n_chk = 0;
    int n_bad = 0;

    wb_trace_buffer #(.DEPTH(16)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .clr               (clr),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_pc          (trace_pc),
        .trace_we          (trace_we),
        .trace_wnum        (trace_wnum),
        .trace_wdata       (trace_wdata),
        .count             (count),
        .overflow          (overflow),
        .commit_cnt        (commit_cnt),
        .drop_cnt          (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [3:0] we,
                         input logic [4:0] wnum, input logic [31:0] wd, input logic rdy);
        debug_wb_pc       = pc;
        debug_wb_rf_we    = we;
        debug_wb_rf_wnum  = wnum;
        debug_wb_rf_wdata = wd;
        trace_ready       = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(32'h0, 4'h0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic pulse_clr();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    logic [31:0] base;

    initial begin
        // reset
        step();
        step();
        resetn = 1'b1;
        step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_commit", 64'(commit_cnt), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);

        // single commit, visible the next cycle
        drive(32'h1C00_0000, 4'hF, 5'd5, 32'h1234_5678, 1'b0);
        step();
        idle();
        chk("c1_valid", 64'(trace_valid), 64'd1);
        chk("c1_pc", 64'(trace_pc), 64'h1C00_0000);
        chk("c1_we", 64'(trace_we), 64'hF);
        chk("c1_wnum", 64'(trace_wnum), 64'd5);
        chk("c1_wdata", 64'(trace_wdata), 64'h1234_5678);
        chk("c1_count", 64'(count), 64'd1);
        chk("c1_commit", 64'(commit_cnt), 64'd1);
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
        chk("c1_popped", 64'(count), 64'd0);

        // non-qualifying commits
        pulse_clr();
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive(32'h400 + 32'(i), 4'h0, 5'd3, 32'hDEAD, 1'b0);
            else            drive(32'h400 + 32'(i), 4'hF, 5'd0, 32'hBEEF, 1'b0);
            step();
        end
        idle();
        chk("nq_count", 64'(count), 64'd0);
        chk("nq_commit", 64'(commit_cnt), 64'd0);
        chk("nq_valid", 64'(trace_valid), 64'd0);

        // overfill with 20 commits
        for (int i = 0; i < 20; i++) begin
            drive(32'h100 + 32'(i), 4'h3, 5'd7, 32'(i), 1'b0);
            step();
        end
        idle();
        chk("of_count", 64'(count), 64'd16);
        chk("of_ovf", 64'(overflow), 64'd1);
        chk("of_drop", 64'(drop_cnt), 64'd4);
        chk("of_commit", 64'(commit_cnt), 64'd20);
`ifdef TRACE_OVERWRITE_EN
        base = 32'h104;
`else
        base = 32'h100;
`endif
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("of_drain_pc", 64'(trace_pc), 64'(base + 32'(i)));
            step();
        end
        idle();
        chk("of_empty_count", 64'(count), 64'd0);
        chk("of_empty_valid", 64'(trace_valid), 64'd0);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            drive(32'h200 + 32'(i), 4'h1, 5'd9, 32'h0, 1'b0);
            step();
        end
        chk("fp_full", 64'(count), 64'd16);
        for (int i = 0; i < 8; i++) begin
            drive(32'h300 + 32'(i), 4'h1, 5'd9, 32'h0, 1'b1);
            chk("fp_pop_pc", 64'(trace_pc), 64'(32'h200 + 32'(i)));
            step();
            chk("fp_count", 64'(count), 64'd16);
        end
        idle();
        chk("fp_drop", 64'(drop_cnt), 64'd4);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("fp_drain_pc", 64'(trace_pc),
                64'((i < 8) ? (32'h208 + 32'(i)) : (32'h300 + 32'(i - 8))));
            step();
        end
        idle();
        chk("fp_empty", 64'(count), 64'd0);

        // clr with simultaneous commit and pop at count 7
        for (int i = 0; i < 7; i++) begin
            drive(32'h500 + 32'(i), 4'hF, 5'd1, 32'h0, 1'b0);
            step();
        end
        idle();
        chk("clr_pre_count", 64'(count), 64'd7);
        drive(32'h600, 4'hF, 5'd2, 32'h0, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle();
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_commit", 64'(commit_cnt), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        chk("clr_valid", 64'(trace_valid), 64'd0);

        // mid-stream reset with count 9 and overflow set
        for (int i = 0; i < 17; i++) begin
            drive(32'h700 + 32'(i), 4'hF, 5'd4, 32'h0, 1'b0);
            step();
        end
        idle();
        trace_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        trace_ready = 1'b0;
        chk("mr_pre_count", 64'(count), 64'd9);
        chk("mr_pre_ovf", 64'(overflow), 64'd1);
        drive(32'h800, 4'hF, 5'd6, 32'h0, 1'b0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        idle();
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_ovf", 64'(overflow), 64'd0);
        chk("mr_commit", 64'(commit_cnt), 64'd0);
        chk("mr_drop", 64'(drop_cnt), 64'd0);
        chk("mr_valid", 64'(trace_valid), 64'd0);
        drive(32'hABC, 4'h8, 5'd31, 32'hCAFE_F00D, 1'b0);
        step();
        idle();
        chk("mr_c_valid", 64'(trace_valid), 64'd1);
        chk("mr_c_pc", 64'(trace_pc), 64'hABC);
        chk("mr_c_wdata", 64'(trace_wdata), 64'hCAFE_F00D);
        chk("mr_c_count", 64'(count), 64'd1);
        chk("mr_c_commit", 64'(commit_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
